mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
// - Round-robin controller that shares one 4:1 mux datapath between 4 requesters.
// - Registers the grant, drives the mux select `s`, and presents the selected lane on `y`.
// - Output side uses a valid/ready handshake; each requester gets an ack pulse when its beat is taken.
// - Sits between producer lanes and a single downstream consumer of the muxed stream.
// PARAMETERS
// - DW         8  width of each data lane and of `y`
// - BURST_LEN  4  max consecutive beats per grant; used only when MUX4_ARB_BURST_EN is defined (>=1)
// PORTS
// - clk      in   1     rising-edge clock, single clock domain
// - rst      in   1     synchronous reset, active-high
// - req      in   4     per-lane request; lane must hold datain stable while its gnt is high
// - datain   in   4*DW  lane i occupies datain[i*DW +: DW]
// - gnt      out  4     registered one-hot grant (all zero when idle)
// - s        out  2     registered mux select = index of granted lane
// - y        out  DW    datain[s*DW +: DW], combinational from registered s
// - y_valid  out  1     registered; high while a lane is granted
// - y_ready  in   1     downstream accept
// - ack      out  4     gnt & {4{y_valid & y_ready}}, combinational; one-hot beat-accepted pulse
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): state=IDLE, gnt=0, s=0, y_valid=0, ptr=0, beat_cnt=0; rst overrides
//   any in-flight beat, no ack is owed for an aborted beat; y = datain[DW-1:0] during/after reset.
// - Priority search: first set bit of the candidate vector scanning ptr, ptr+1, ... mod 4.
// - States: IDLE, BUSY.
// - IDLE: if req!=0 -> pick lane k, next cycle gnt=1<<k, s=k, y_valid=1, state=BUSY; else stay IDLE.
//   Grant latency: 1 cycle from req sampled high to y_valid.
// - BUSY, accept (y_valid & y_ready): ptr <= s+1 (wraps 3->0). Candidates = req with bit s masked to 0.
//   If candidates!=0 -> grant next lane back-to-back (no bubble); else gnt=0, y_valid=0, state=IDLE.
//   A lone requester holding req high is re-granted after one idle cycle.
// - BUSY, no accept: gnt, s, y_valid hold stable (backpressure, any number of cycles).
// - BUSY, req[s]==0 and no accept: abort; next cycle gnt=0, y_valid=0, state=IDLE, ptr unchanged.
// - Accept and req[s] falling in the same cycle: treated as accept.
// - Requests from non-granted lanes never disturb the current grant.
// - At most one gnt/ack bit ever high; s only changes on a cycle where a new grant is issued.
// CONFIGURATION
// - MUX4_ARB_BURST_EN undefined: one beat per grant, rotate on every accept; no beat_cnt register.
// - MUX4_ARB_BURST_EN defined: 2-bit-min beat_cnt (clog2(BURST_LEN)), cleared on each new grant.
//   On accept, if req[s]==1 and beat_cnt < BURST_LEN-1: keep gnt/s, y_valid=1, beat_cnt++, ptr unchanged.
//   Otherwise rotate exactly as the non-burst accept rule. Abort rule unchanged.
// TESTING
// - rst=1 for 2 cycles with req=4'b1111 -> gnt=0, s=0, y_valid=0, ack=0 throughout.
// - req=4'b0100, lane2=8'hA5, y_ready=1 -> next cycle gnt=4'b0100, s=2, y=8'hA5, y_valid=1, ack=4'b0100.
// - req=4'b1111 held, y_ready=1, burst off -> grants lane 0,1,2,3,0 on consecutive cycles, no bubbles.
// - Lane1 granted, y_ready=0 for 5 cycles -> gnt/s/y stable, ack=0; y_ready=1 -> ack=4'b0010 one cycle.
// - Lane1 granted, y_ready=0, req[1] dropped -> next cycle gnt=0, y_valid=0; later req=4'b0011 grants lane1.
// - Burst on, BURST_LEN=4, req=4'b0011 held, y_ready=1 -> lane0 4 beats, then lane1 4 beats, repeat;
//   assert rst mid-burst -> next cycle gnt=0, y_valid=0, restart at lane0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters, valid/ready output.
// Define MUX4_ARB_BURST_EN to allow up to BURST_LEN consecutive beats per grant.
module mux4_rr_arbiter #(
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] datain,
  output logic [3:0]      gnt,
  output logic [1:0]      s,
  output logic [DW-1:0]   y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [3:0]      ack
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_s, w_s_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic       r_valid, w_valid_nxt;
  logic       w_accept;
  logic       w_hold;
  logic       w_new_grant;
  logic [1:0] w_ptr_rot;
  logic [2:0] w_pick_idle, w_pick_rot;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!res[2] && cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_accept    = r_valid & y_ready;
  assign w_ptr_rot   = r_s + 2'd1;
  assign w_pick_idle = rr_pick(req, r_ptr);
  assign w_pick_rot  = rr_pick(req & ~(4'b0001 << r_s), w_ptr_rot);

`ifdef MUX4_ARB_BURST_EN
  localparam int unsigned CW = ($clog2(BURST_LEN) < 2) ? 2 : $clog2(BURST_LEN);
  logic [CW-1:0] r_beat_cnt;

  assign w_hold = req[r_s] && (r_beat_cnt < CW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst)                      r_beat_cnt <= '0;
    else if (w_new_grant)         r_beat_cnt <= '0;
    else if (w_accept && w_hold)  r_beat_cnt <= r_beat_cnt + 1'b1;
  end
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_s_nxt     = r_s;
    w_ptr_nxt   = r_ptr;
    w_valid_nxt = r_valid;
    w_new_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_idle[2]) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = 4'b0001 << w_pick_idle[1:0];
          w_s_nxt     = w_pick_idle[1:0];
          w_valid_nxt = 1'b1;
          w_new_grant = 1'b1;
        end
      end
      BUSY: begin
        // Accept wins over a request dropping in the same cycle.
        if (w_accept) begin
          if (!w_hold) begin
            w_ptr_nxt = w_ptr_rot;
            if (w_pick_rot[2]) begin
              w_gnt_nxt   = 4'b0001 << w_pick_rot[1:0];
              w_s_nxt     = w_pick_rot[1:0];
              w_new_grant = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_gnt_nxt   = '0;
              w_valid_nxt = 1'b0;
            end
          end
        end else if (!req[r_s]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_s     <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_s     <= w_s_nxt;
      r_ptr   <= w_ptr_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign s       = r_s;
  assign y_valid = r_valid;
  assign y       = datain[r_s*DW +: DW];
  assign ack     = r_gnt & {4{w_accept}};

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_mux4_rr_arbiter;

  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*DW-1:0] datain;
  logic [3:0]      gnt;
  logic [1:0]      s;
  logic [DW-1:0]   y;
  logic            y_valid;
  logic            y_ready;
  logic [3:0]      ack;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DW(DW), .BURST_LEN(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .datain  (datain),
    .gnt     (gnt),
    .s       (s),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .ack     (ack)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_s,
                            input logic [7:0] e_y, input logic e_valid, input logic [3:0] e_ack);
    check({tag, ".gnt"},   32'(gnt),     32'(e_gnt));
    check({tag, ".s"},     32'(s),       32'(e_s));
    check({tag, ".y"},     32'(y),       32'(e_y));
    check({tag, ".valid"}, 32'(y_valid), 32'(e_valid));
    check({tag, ".ack"},   32'(ack),     32'(e_ack));
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b1111;
    y_ready = 1'b1;
    datain  = {8'h3C, 8'hA5, 8'h22, 8'h11};

    @(negedge clk); expect_out("rst1", 4'b0000, 2'd0, 8'h11, 1'b0, 4'b0000);
    @(negedge clk); expect_out("rst2", 4'b0000, 2'd0, 8'h11, 1'b0, 4'b0000);

`ifdef MUX4_ARB_BURST_EN
    begin
      logic [3:0] b_gnt [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
      logic [1:0] b_s   [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
      logic [7:0] b_y   [10] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22,
                                 8'h22, 8'h22, 8'h22, 8'h11, 8'h11};
      rst = 1'b0;
      req = 4'b0011;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        expect_out($sformatf("burst%0d", i), b_gnt[i], b_s[i], b_y[i], 1'b1, b_gnt[i]);
      end
      rst = 1'b1;
      @(negedge clk); expect_out("burst_rst", 4'b0000, 2'd0, 8'h11, 1'b0, 4'b0000);
      rst = 1'b0;
      @(negedge clk); expect_out("burst_restart", 4'b0001, 2'd0, 8'h11, 1'b1, 4'b0001);
    end
`else
    begin
      logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] rr_s   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [7:0] rr_y   [5] = '{8'h11, 8'h22, 8'hA5, 8'h3C, 8'h11};

      rst = 1'b0;
      req = 4'b0100;
      @(negedge clk); expect_out("lane2", 4'b0100, 2'd2, 8'hA5, 1'b1, 4'b0100);
      rst = 1'b1;
      req = 4'b1111;
      @(negedge clk); expect_out("rst_inflight", 4'b0000, 2'd0, 8'h11, 1'b0, 4'b0000);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        expect_out($sformatf("rr%0d", i), rr_gnt[i], rr_s[i], rr_y[i], 1'b1, rr_gnt[i]);
      end
      req = 4'b0010;

      @(negedge clk);
      check("lane1.gnt", 32'(gnt), 32'h2);
      check("lane1.s",   32'(s),   32'h1);
      check("lane1.y",   32'(y),   32'h22);
      y_ready = 1'b0;
      req     = 4'b1111;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        expect_out($sformatf("bp%0d", i), 4'b0010, 2'd1, 8'h22, 1'b1, 4'b0000);
      end
      req = 4'b1101;

      @(negedge clk); expect_out("abort", 4'b0000, 2'd1, 8'h22, 1'b0, 4'b0000);
      req = 4'b0011;
      @(negedge clk); expect_out("regrant", 4'b0010, 2'd1, 8'h22, 1'b1, 4'b0000);
      y_ready = 1'b1;
      #1 check("ack_release", 32'(ack), 32'h2);

      @(negedge clk); expect_out("b2b", 4'b0001, 2'd0, 8'h11, 1'b1, 4'b0001);
      req = 4'b0001;
      @(negedge clk); expect_out("lone_idle", 4'b0000, 2'd0, 8'h11, 1'b0, 4'b0000);
      @(negedge clk); expect_out("lone_regrant", 4'b0001, 2'd0, 8'h11, 1'b1, 4'b0001);
      @(negedge clk); expect_out("lone_idle2", 4'b0000, 2'd0, 8'h11, 1'b0, 4'b0000);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
